// File: rtl/amo_ctrl_pkg.sv
// ============================================================================
// Module      : amo_ctrl_pkg
// Description : AMO op-codes and helpers shared by amo_ctrl and amo_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package amo_ctrl_pkg;

    localparam int c_AMOOP_LEN = 4;

    typedef logic [c_AMOOP_LEN-1:0] amoop_t;

    localparam amoop_t c_AMOOP_LR   = 4'd0;
    localparam amoop_t c_AMOOP_SC   = 4'd1;
    localparam amoop_t c_AMOOP_SWAP = 4'd2;
    localparam amoop_t c_AMOOP_ADD  = 4'd3;
    localparam amoop_t c_AMOOP_XOR  = 4'd4;
    localparam amoop_t c_AMOOP_AND  = 4'd5;
    localparam amoop_t c_AMOOP_OR   = 4'd6;
    localparam amoop_t c_AMOOP_MIN  = 4'd7;
    localparam amoop_t c_AMOOP_MAX  = 4'd8;
    localparam amoop_t c_AMOOP_MINU = 4'd9;
    localparam amoop_t c_AMOOP_MAXU = 4'd10;

    // Word accesses only: any set low address bit is a misalignment fault.
    function automatic logic amo_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/amo_alu.sv
// ============================================================================
// Module      : amo_alu
// Description : Combinational AMO update function f(old, rs2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amo_alu
    import amo_ctrl_pkg::*;
#(
    parameter int AMOOP_W = c_AMOOP_LEN,
    parameter int XLEN    = 32
) (
    input  logic [AMOOP_W-1:0] i_op,
    input  logic [XLEN-1:0]    i_old,
    input  logic [XLEN-1:0]    i_rs2,
    output logic [XLEN-1:0]    o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            c_AMOOP_SWAP: o_result = i_rs2;
            c_AMOOP_ADD:  o_result = i_old + i_rs2;
            c_AMOOP_XOR:  o_result = i_old ^ i_rs2;
            c_AMOOP_AND:  o_result = i_old & i_rs2;
            c_AMOOP_OR:   o_result = i_old | i_rs2;
            c_AMOOP_MIN:  o_result = ($signed(i_old) < $signed(i_rs2)) ? i_old : i_rs2;
            c_AMOOP_MAX:  o_result = ($signed(i_old) > $signed(i_rs2)) ? i_old : i_rs2;
            c_AMOOP_MINU: o_result = (i_old < i_rs2) ? i_old : i_rs2;
            c_AMOOP_MAXU: o_result = (i_old > i_rs2) ? i_old : i_rs2;
            default:      o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/amo_ctrl.sv
// ============================================================================
// Module      : amo_ctrl
// Description : Atomic memory operation sequencer (LR/SC and RMW AMOs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amo_ctrl
    import amo_ctrl_pkg::*;
#(
    parameter int AMOOP_W = c_AMOOP_LEN,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               amo_valid_i,
    input  logic [AMOOP_W-1:0] amo_op_i,
    input  logic [XLEN-1:0]    addr_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic               flush_i,
    input  logic               resv_clear_i,
    input  logic               amo_ready_i,
    output logic               mem_req_valid_o,
    output logic               mem_req_we_o,
    output logic [XLEN-1:0]    mem_req_addr_o,
    output logic [XLEN-1:0]    mem_req_wdata_o,
    input  logic               mem_req_ready_i,
    input  logic               mem_rvalid_i,
    input  logic               mem_wack_i,
    input  logic               mem_err_i,
    input  logic [XLEN-1:0]    mem_rdata_i,
    output logic               amo_done_o,
    output logic               amo_err_o,
    output logic [XLEN-1:0]    amo_result_o,
    output logic               amo_busy_o
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_WR_REQ  = 3'd3;
    localparam logic [2:0] c_ST_WR_WAIT = 3'd4;
    localparam logic [2:0] c_ST_DONE    = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [AMOOP_W-1:0] r_op;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_rs2;
    logic [XLEN-1:0]    r_old;
    logic [XLEN-1:0]    r_result;
    logic               r_err;
    logic               r_resv_valid;
    logic [XLEN-1:0]    r_resv_addr;

    logic [XLEN-1:0]    w_alu_out;
    logic [XLEN-1:0]    w_wdata;
    logic               w_accept;
    logic               w_misaligned;
    logic               w_in_sc;
    logic               w_sc_hit;
    logic               w_op_is_sc;
    logic               w_op_is_lr;
    logic               w_resv_set;
    logic               w_sc_end;

    assign w_accept     = (r_state == c_ST_IDLE) && amo_valid_i && !flush_i;
    assign w_misaligned = amo_misaligned(addr_i[1:0]);
    assign w_in_sc      = (amo_op_i == c_AMOOP_SC);
    // A same-cycle reservation kill must also defeat an SC being accepted.
    assign w_sc_hit     = r_resv_valid && !resv_clear_i && (r_resv_addr == addr_i);
    assign w_op_is_sc   = (r_op == c_AMOOP_SC);
    assign w_op_is_lr   = (r_op == c_AMOOP_LR);
    assign w_resv_set   = (r_state == c_ST_RD_WAIT) && mem_rvalid_i && !mem_err_i && w_op_is_lr;
    assign w_sc_end     = (w_accept && w_in_sc && (w_misaligned || !w_sc_hit))
                        || ((r_state == c_ST_WR_WAIT) && mem_wack_i && w_op_is_sc);

    amo_alu #(
        .AMOOP_W (AMOOP_W),
        .XLEN    (XLEN)
    ) u_amo_alu (
        .i_op     (r_op),
        .i_old    (r_old),
        .i_rs2    (r_rs2),
        .o_result (w_alu_out)
    );

    assign w_wdata = w_op_is_sc ? r_rs2 : w_alu_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned)  w_state_nxt = c_ST_DONE;
                    else if (w_in_sc)  w_state_nxt = w_sc_hit ? c_ST_WR_REQ : c_ST_DONE;
                    else               w_state_nxt = c_ST_RD_REQ;
                end
            end
            // Once the read is accepted the sequence is atomic; flush is ignored.
            c_ST_RD_REQ: begin
                if (mem_req_ready_i)  w_state_nxt = c_ST_RD_WAIT;
                else if (flush_i)     w_state_nxt = c_ST_IDLE;
            end
            c_ST_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = (mem_err_i || w_op_is_lr) ? c_ST_DONE : c_ST_WR_REQ;
                end
            end
            c_ST_WR_REQ:  if (mem_req_ready_i) w_state_nxt = c_ST_WR_WAIT;
            c_ST_WR_WAIT: if (mem_wack_i)      w_state_nxt = c_ST_DONE;
            c_ST_DONE:    if (amo_ready_i)     w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;
        amo_done_o      = 1'b0;
        amo_err_o       = 1'b0;
        amo_result_o    = '0;
        case (r_state)
            c_ST_RD_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = r_addr;
            end
            c_ST_WR_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = r_addr;
                mem_req_wdata_o = w_wdata;
            end
            c_ST_DONE: begin
                amo_done_o   = 1'b1;
                amo_err_o    = r_err;
                amo_result_o = r_result;
            end
            default: ;
        endcase
    end

    assign amo_busy_o = amo_valid_i & ~amo_done_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_addr   <= '0;
            r_rs2    <= '0;
            r_old    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= amo_op_i;
                        r_addr   <= addr_i;
                        r_rs2    <= rs2_data_i;
                        r_old    <= '0;
                        r_err    <= w_misaligned;
                        r_result <= (w_in_sc && !w_misaligned && !w_sc_hit) ? XLEN'(1) : '0;
                    end
                end
                c_ST_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_old    <= mem_rdata_i;
                        r_result <= mem_rdata_i;
                        r_err    <= mem_err_i;
                    end
                end
                c_ST_WR_WAIT: begin
                    if (mem_wack_i) begin
                        if (w_op_is_sc) r_result <= '0;
                        if (mem_err_i)  r_err    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resv_valid <= 1'b0;
            r_resv_addr  <= '0;
        end else if (resv_clear_i || w_sc_end) begin
            r_resv_valid <= 1'b0;
        end else if (w_resv_set) begin
            r_resv_valid <= 1'b1;
            r_resv_addr  <= r_addr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_amo_ctrl.sv
// ============================================================================
// Module      : tb_amo_ctrl
// Description : Self-checking bench for amo_ctrl with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_amo_ctrl;
    import amo_ctrl_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            amo_valid_i;
    logic [3:0]      amo_op_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            resv_clear_i;
    logic            amo_ready_i;
    logic            mem_req_valid_o;
    logic            mem_req_we_o;
    logic [XLEN-1:0] mem_req_addr_o;
    logic [XLEN-1:0] mem_req_wdata_o;
    logic            mem_req_ready_i;
    logic            mem_rvalid_i;
    logic            mem_wack_i;
    logic            mem_err_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            amo_done_o;
    logic            amo_err_o;
    logic [XLEN-1:0] amo_result_o;
    logic            amo_busy_o;

    amo_ctrl #(.AMOOP_W(c_AMOOP_LEN), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .amo_valid_i(amo_valid_i), .amo_op_i(amo_op_i),
        .addr_i(addr_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .resv_clear_i(resv_clear_i), .amo_ready_i(amo_ready_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_wack_i(mem_wack_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
        .amo_done_o(amo_done_o), .amo_err_o(amo_err_o),
        .amo_result_o(amo_result_o), .amo_busy_o(amo_busy_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    bit          ref_resv;
    logic [31:0] ref_resv_addr;
    bit          rand_wait, hold_off, inj_err;
    int          rd_cnt, wr_cnt, done_cnt;
    int          n_cmp, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Spec-level model: word memory plus a single reservation.
    function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                                     input bit rerr, output logic [31:0] res, output logic err);
        logic [31:0] old;
        logic [31:0] nv;
        int idx;
        idx = int'(a[9:2]);
        res = 32'd0;
        err = 1'b0;
        if (a[1:0] != 2'b00) begin
            err = 1'b1;
            if (op == c_AMOOP_SC) ref_resv = 1'b0;
            return;
        end
        if (op == c_AMOOP_SC) begin
            if (ref_resv && ref_resv_addr == a) ref_mem[idx] = d;
            else res = 32'd1;
            ref_resv = 1'b0;
            return;
        end
        old = ref_mem[idx];
        res = old;
        if (rerr) begin
            err = 1'b1;
            return;
        end
        if (op == c_AMOOP_LR) begin
            ref_resv = 1'b1;
            ref_resv_addr = a;
            return;
        end
        case (op)
            c_AMOOP_SWAP: nv = d;
            c_AMOOP_ADD:  nv = old + d;
            c_AMOOP_XOR:  nv = old ^ d;
            c_AMOOP_AND:  nv = old & d;
            c_AMOOP_OR:   nv = old | d;
            c_AMOOP_MIN:  nv = ($signed(old) < $signed(d)) ? old : d;
            c_AMOOP_MAX:  nv = ($signed(old) > $signed(d)) ? old : d;
            c_AMOOP_MINU: nv = (old < d) ? old : d;
            default:      nv = (old > d) ? old : d;
        endcase
        ref_mem[idx] = nv;
    endfunction

    // Memory responder: random or zero wait states, tracks accepted requests.
    initial begin : responder
        int          pend;
        int          dly;
        logic [31:0] p_addr, p_wdata;
        bit          prev_wait, prev_done;
        logic [64:0] pv_req;
        pend = 0; dly = 0; prev_wait = 0; prev_done = 0; pv_req = '0;
        p_addr = '0; p_wdata = '0;
        mem_req_ready_i = 0; mem_rvalid_i = 0; mem_wack_i = 0; mem_err_i = 0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_rvalid_i = 0; mem_wack_i = 0; mem_err_i = 0; mem_rdata_i = '0;
            if (rst) begin
                pend = 0; prev_wait = 0; prev_done = 0; mem_req_ready_i = 0;
                continue;
            end
            if (amo_done_o && !prev_done) done_cnt++;
            prev_done = amo_done_o;
            if (prev_wait && mem_req_valid_o)
                check("req_stable", {mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} == pv_req, 1);
            if (pend != 0) begin
                if (dly == 0) begin
                    if (pend == 1) begin
                        mem_rvalid_i = 1; mem_rdata_i = mem[p_addr[9:2]]; mem_err_i = inj_err;
                    end else begin
                        mem_wack_i = 1; mem[p_addr[9:2]] = p_wdata;
                    end
                    pend = 0;
                end else begin
                    dly--;
                end
            end
            mem_req_ready_i = hold_off ? 1'b0 : (rand_wait ? 1'($urandom_range(0, 1)) : 1'b1);
            if (pend == 0 && mem_req_valid_o && mem_req_ready_i) begin
                pend = mem_req_we_o ? 2 : 1;
                p_addr = mem_req_addr_o; p_wdata = mem_req_wdata_o;
                dly = rand_wait ? int'($urandom_range(0, 2)) : 0;
                if (mem_req_we_o) wr_cnt++; else rd_cnt++;
                prev_wait = 0;
            end else begin
                prev_wait = mem_req_valid_o;
                pv_req = {mem_req_we_o, mem_req_addr_o, mem_req_wdata_o};
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d, input int hold,
                          output logic [31:0] res, output logic err, output int lat);
        int d0, cyc;
        @(negedge clk);
        amo_valid_i = 1; amo_op_i = op; addr_i = a; rs2_data_i = d; amo_ready_i = 0;
        d0 = done_cnt;
        #1 check("busy_on_issue", amo_busy_o, 1);
        cyc = 0;
        while (!amo_done_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc; res = amo_result_o; err = amo_err_o;
        if (!amo_done_o) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles, required within 100", cyc);
            amo_valid_i = 0;
            return;
        end
        check("busy_in_done", amo_busy_o, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("done_held", {amo_done_o, amo_err_o, amo_result_o}, {1'b1, err, res});
        end
        amo_ready_i = 1;
        @(negedge clk);
        amo_ready_i = 0; amo_valid_i = 0;
        check("done_cleared", amo_done_o, 0);
        @(negedge clk);
        check("done_once", done_cnt - d0, 1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, rs2, init, exp_mem, exp_res;
        logic        exp_err;
        int          exp_wr, exp_lat;
    } vec_t;

    vec_t        vt [12];
    logic [31:0] res, mres;
    logic        err, merr;
    int          lat, w0, r0, d0;
    logic [31:0] ra, rd2;
    logic [3:0]  rop;

    initial begin
        vt[0]  = '{c_AMOOP_ADD,  32'h100, 32'd3,        32'd5,        32'd8,        32'd5,        1'b0, 1, 5};
        vt[1]  = '{c_AMOOP_SWAP, 32'h104, 32'hCAFEBABE, 32'h12345678, 32'hCAFEBABE, 32'h12345678, 1'b0, 1, 5};
        vt[2]  = '{c_AMOOP_XOR,  32'h108, 32'h0FF00FF0, 32'hFF00FF00, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1, 5};
        vt[3]  = '{c_AMOOP_AND,  32'h10C, 32'h0FF00FF0, 32'hFF00FF00, 32'h0F000F00, 32'hFF00FF00, 1'b0, 1, 5};
        vt[4]  = '{c_AMOOP_OR,   32'h110, 32'h0FF00FF0, 32'hFF00FF00, 32'hFFF0FFF0, 32'hFF00FF00, 1'b0, 1, 5};
        vt[5]  = '{c_AMOOP_MIN,  32'h114, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 5};
        vt[6]  = '{c_AMOOP_MINU, 32'h118, 32'd1,        32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 1, 5};
        vt[7]  = '{c_AMOOP_MAX,  32'h11C, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1, 5};
        vt[8]  = '{c_AMOOP_MAXU, 32'h120, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1, 5};
        vt[9]  = '{c_AMOOP_ADD,  32'h124, 32'd2,        32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 1, 5};
        vt[10] = '{c_AMOOP_ADD,  32'h102, 32'd3,        32'hAAAA0000, 32'hAAAA0000, 32'd0,        1'b1, 0, 1};
        vt[11] = '{c_AMOOP_LR,   32'h128, 32'd0,        32'h55,       32'h55,       32'h55,       1'b0, 0, 3};

        n_cmp = 0; n_fail = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        rand_wait = 0; hold_off = 0; inj_err = 0; ref_resv = 0; ref_resv_addr = '0;
        amo_valid_i = 0; amo_op_i = '0; addr_i = '0; rs2_data_i = '0;
        flush_i = 0; resv_clear_i = 0; amo_ready_i = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1;
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", |{mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
                                     amo_done_o, amo_err_o, amo_result_o, amo_busy_o}, 0);
        @(negedge clk);
        rst = 0;

        // Directed vectors, zero-wait memory.
        for (int i = 0; i < 12; i++) begin
            mem[vt[i].addr[9:2]] = vt[i].init;
            ref_mem[vt[i].addr[9:2]] = vt[i].init;
            w0 = wr_cnt;
            model_op(vt[i].op, vt[i].addr, vt[i].rs2, 1'b0, mres, merr);
            run_op(vt[i].op, vt[i].addr, vt[i].rs2, 0, res, err, lat);
            check($sformatf("vec%0d_result", i), res, vt[i].exp_res);
            check($sformatf("vec%0d_err", i), err, vt[i].exp_err);
            check($sformatf("vec%0d_mem", i), mem[vt[i].addr[9:2]], vt[i].exp_mem);
            check($sformatf("vec%0d_writes", i), wr_cnt - w0, vt[i].exp_wr);
            check($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
        end

        // LR then SC succeeds; a second SC fails without writing.
        mem[8'h80] = 32'h77; ref_mem[8'h80] = 32'h77;
        model_op(c_AMOOP_LR, 32'h200, 0, 0, mres, merr);
        run_op(c_AMOOP_LR, 32'h200, 0, 0, res, err, lat);
        check("lr200_result", res, 32'h77);
        w0 = wr_cnt;
        model_op(c_AMOOP_SC, 32'h200, 9, 0, mres, merr);
        run_op(c_AMOOP_SC, 32'h200, 32'd9, 0, res, err, lat);
        check("sc1_result", res, 0);
        check("sc1_mem", mem[8'h80], 9);
        check("sc1_writes", wr_cnt - w0, 1);
        check("sc1_latency", lat, 3);
        w0 = wr_cnt;
        model_op(c_AMOOP_SC, 32'h200, 32'h11, 0, mres, merr);
        run_op(c_AMOOP_SC, 32'h200, 32'h11, 0, res, err, lat);
        check("sc2_result", res, 1);
        check("sc2_writes", wr_cnt - w0, 0);
        check("sc2_mem", mem[8'h80], 9);

        // Read error aborts the RMW before any write.
        inj_err = 1; w0 = wr_cnt;
        model_op(c_AMOOP_ADD, 32'h104, 1, 1, mres, merr);
        run_op(c_AMOOP_ADD, 32'h104, 32'd1, 0, res, err, lat);
        inj_err = 0;
        check("rderr_err", err, 1);
        check("rderr_writes", wr_cnt - w0, 0);

        // Flush while the read request is still waiting for ready.
        hold_off = 1; r0 = rd_cnt; d0 = done_cnt;
        @(negedge clk);
        amo_valid_i = 1; amo_op_i = c_AMOOP_ADD; addr_i = 32'h100; rs2_data_i = 32'd1;
        @(negedge clk);
        check("flush_rdreq_valid", mem_req_valid_o, 1);
        flush_i = 1; amo_valid_i = 0;
        @(negedge clk);
        flush_i = 0;
        check("flush_to_idle", mem_req_valid_o, 0);
        hold_off = 0;
        repeat (4) @(negedge clk);
        check("flush_no_done", done_cnt - d0, 0);
        check("flush_no_read", rd_cnt - r0, 0);

        // Reservation killed by resv_clear_i; done held while ready is low.
        model_op(c_AMOOP_LR, 32'h204, 0, 0, mres, merr);
        run_op(c_AMOOP_LR, 32'h204, 0, 0, res, err, lat);
        @(negedge clk); resv_clear_i = 1;
        @(negedge clk); resv_clear_i = 0;
        ref_resv = 0;
        w0 = wr_cnt;
        model_op(c_AMOOP_SC, 32'h204, 5, 0, mres, merr);
        run_op(c_AMOOP_SC, 32'h204, 32'd5, 3, res, err, lat);
        check("sc_after_clear_result", res, 1);
        check("sc_after_clear_writes", wr_cnt - w0, 0);

        // Reset mid-transaction abandons it and drops the reservation.
        model_op(c_AMOOP_LR, 32'h208, 0, 0, mres, merr);
        run_op(c_AMOOP_LR, 32'h208, 0, 0, res, err, lat);
        hold_off = 1;
        @(negedge clk);
        amo_valid_i = 1; amo_op_i = c_AMOOP_ADD; addr_i = 32'h300; rs2_data_i = 32'd1;
        repeat (2) @(negedge clk);
        check("pre_reset_valid", mem_req_valid_o, 1);
        rst = 1;
        #1 check("midreset_outputs", |{mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o,
                                        amo_done_o, amo_err_o, amo_result_o}, 0);
        amo_valid_i = 0;
        @(negedge clk);
        rst = 0; hold_off = 0; ref_resv = 0;
        w0 = wr_cnt;
        model_op(c_AMOOP_SC, 32'h208, 5, 0, mres, merr);
        run_op(c_AMOOP_SC, 32'h208, 32'd5, 0, res, err, lat);
        check("sc_after_reset_result", res, 1);
        check("sc_after_reset_writes", wr_cnt - w0, 0);

        // Randomized traffic against the model with random wait states.
        rand_wait = 1;
        for (int n = 0; n < 150; n++) begin
            rop = 4'($urandom_range(0, 10));
            ra  = 32'h300 + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 15) == 0) ra = ra + 32'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
                0:       rd2 = 32'h80000000;
                1:       rd2 = 32'($urandom_range(0, 7));
                default: rd2 = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); resv_clear_i = 1;
                @(negedge clk); resv_clear_i = 0;
                ref_resv = 0;
            end
            model_op(rop, ra, rd2, 0, mres, merr);
            run_op(rop, ra, rd2, int'($urandom_range(0, 2)), res, err, lat);
            check($sformatf("rnd%0d_op%0d_result", n, rop), res, mres);
            check($sformatf("rnd%0d_op%0d_err", n, rop), err, merr);
            check($sformatf("rnd%0d_op%0d_mem", n, rop), mem[ra[9:2]], ref_mem[ra[9:2]]);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/amo_ctrl.md
AMO_CTRL -- requirements
Module: amo_ctrl

Interface
REQ-001 SHALL have parameter AMOOP_W, default `AMOOP_LEN, amo op-code width.
REQ-002 SHALL have parameter XLEN, default 32, data/address width.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port amo_valid_i  in  1  AMO instruction present in EX/MEM; held until accepted.
REQ-006 SHALL have port amo_op_i  in  AMOOP_W  LR/SC/SWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU.
REQ-007 SHALL have port addr_i  in  XLEN  rs1 effective address.
REQ-008 SHALL have port rs2_data_i  in  XLEN  AMO source operand.
REQ-009 SHALL have port flush_i  in  1  pipeline flush.
REQ-010 SHALL have port resv_clear_i  in  1  trap/xret entry; kills reservation.
REQ-011 SHALL have port amo_ready_i  in  1  pipeline consumed result.
REQ-012 SHALL have ports mem_req_valid_o/mem_req_we_o  out  1  memory request / write-enable.
REQ-013 SHALL have ports mem_req_addr_o/mem_req_wdata_o  out  XLEN  request address / write data.
REQ-014 SHALL have port mem_req_ready_i  in  1  request accepted.
REQ-015 SHALL have ports mem_rvalid_i, mem_wack_i, mem_err_i  in  1  read data valid, write ack, error with either.
REQ-016 SHALL have port mem_rdata_i  in  XLEN  read data.
REQ-017 SHALL have ports amo_done_o/amo_err_o  out  1  result valid / access or misalign fault.
REQ-018 SHALL have port amo_result_o  out  XLEN  value written to rd.
REQ-019 SHALL have port amo_busy_o  out  1  stall request (amo_valid_i & ~amo_done_o).

Function
REQ-020 SHALL implement FSM IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-021 SHALL in IDLE with amo_valid_i latch op, addr, rs2 and go: misaligned (addr[1:0]!=0) -> DONE, err=1, no bus access; SC -> WR_REQ if reservation valid and address match, else DONE result=1; otherwise -> RD_REQ.
REQ-022 SHALL in RD_REQ drive valid=1, we=0, addr=latched; on ready -> RD_WAIT.
REQ-023 SHALL in RD_WAIT on rvalid latch rdata as result; err -> DONE err=1; LR -> set reservation(addr), DONE; other AMO -> WR_REQ.
REQ-024 SHALL in WR_REQ drive valid=1, we=1, wdata=SC?rs2:f(old,rs2); on ready -> WR_WAIT.
REQ-025 SHALL compute f: SWAP rs2; ADD old+rs2 mod 2^32; XOR/AND/OR bitwise; MIN/MAX signed; MINU/MAXU unsigned.
REQ-026 SHALL in WR_WAIT on wack -> DONE; SC result=0, AMO result=old value; err -> err=1.
REQ-027 SHALL hold amo_done_o=1 with stable result/err in DONE until amo_ready_i, then IDLE; no new op starts in that exit cycle.
REQ-028 SHALL clear reservation on any SC completion (success or fail), on resv_clear_i, and on reset; resv_clear_i wins over same-cycle LR set.
REQ-029 SHALL honour flush_i only in IDLE and RD_REQ (request not yet accepted) -> IDLE, no done; after first accept, sequence completes atomically.
REQ-030 SHALL keep mem_req_valid_o asserted and address/data stable until ready.
REQ-031 SHALL have minimum latency of 4 cycles from accept to done (0-wait memory) for RMW AMO, 2 for LR.

Reset
REQ-032 SHALL on rst enter IDLE; all outputs 0; reservation invalid; latched regs 0.
REQ-033 SHALL on rst mid-transaction abandon it; no retry.

Structure
REQ-034 SHALL take AMOOP_* codes and AMOOP_LEN from sysconfig.v; state encodings local.
REQ-035 SHALL place f() in sub-module amo_alu (combinational).

Verification
REQ-036 SHALL cover AMOADD, mem[0x100]=5, rs2=3 -> write 8 to 0x100, result=5, done once.
REQ-037 SHALL cover LR 0x200 then SC 0x200 rs2=9 -> mem=9, result=0; second SC -> result=1, no write.
REQ-038 SHALL cover AMOMIN old=0xFFFFFFFF, rs2=1 -> write 0xFFFFFFFF; AMOMINU -> write 1.
REQ-039 SHALL cover addr=0x102 -> err=1, no mem_req_valid_o, done.
REQ-040 SHALL cover mem_err_i on read -> err=1, no write issued; flush in RD_REQ -> IDLE, no done.
REQ-041 SHALL cover LR, resv_clear_i pulse, SC -> result=1; amo_ready_i low 3 cycles -> done held.
